// File: rtl/alu_seq_pkg.sv
// Shared types for the multi-precision ALU sequencer: opcodes, FSM states
// and the helper that tells which opcodes chain carry/borrow between limbs.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LD  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_NOT = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_XOR = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } seq_state_e;

    function automatic logic is_arith(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// Single-limb combinational ALU; carry/borrow handling lives in the sequencer.
module alu_seq_alu
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] ci_ext;
    assign ci_ext = {{(WIDTH-1){1'b0}}, ci};

    always_comb begin
        r = '0;
        case (alu_op_e'(op))
            OP_NOP:  r = b;
            OP_LD:   r = b;
            OP_ADD:  r = a + b + ci_ext;
            OP_SUB:  r = a - b - ci_ext;
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-precision sequencer: streams operand limbs LS-first through one ALU,
// chaining carry/borrow. Optional statistics counters under ALU_SEQ_STATS_EN.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_LIMBS = 16,
    localparam int LEN_W    = $clog2(MAX_LIMBS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_ci,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             done,
    output logic             done_co,
    output logic             done_ov,
    output logic             done_zero
`ifdef ALU_SEQ_STATS_EN
    , output logic [15:0]    stat_cmds
    , output logic [15:0]    stat_limbs
`endif
);

    seq_state_e       state_reg, state_next;
    alu_op_e          op_reg, op_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic             carry_reg, carry_next;
    logic             zero_reg, zero_next;
    logic             ov_reg, ov_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic             out_valid_reg, out_valid_next;
    logic             out_last_reg, out_last_next;
    logic             done_reg, done_next;
    logic             done_co_reg, done_co_next;
    logic             done_ov_reg, done_ov_next;
    logic             done_zero_reg, done_zero_next;

    logic [WIDTH-1:0] limb_r;
    logic [WIDTH:0]   sum_ext, diff_ext;
    logic             limb_co, limb_ov;
    logic             unused_low_bits;

    alu_seq_alu #(.WIDTH(WIDTH)) alu (
        .op (op_reg),
        .a  (in_a),
        .b  (in_b),
        .ci (carry_reg),
        .r  (limb_r)
    );

    // Carry/borrow come from the extended-width sums, not from the ALU.
    assign sum_ext  = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, carry_reg};
    assign diff_ext = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, carry_reg};
    assign unused_low_bits = ^{sum_ext[WIDTH-1:0], diff_ext[WIDTH-1:0]};

    always_comb begin
        limb_co = 1'b0;
        limb_ov = 1'b0;
        if (op_reg == OP_ADD) begin
            limb_co = sum_ext[WIDTH];
            limb_ov = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (limb_r[WIDTH-1] != in_a[WIDTH-1]);
        end else if (op_reg == OP_SUB) begin
            limb_co = diff_ext[WIDTH];
            limb_ov = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (limb_r[WIDTH-1] != in_a[WIDTH-1]);
        end
    end

    assign cmd_ready = (state_reg == ST_IDLE) && !rst;
    assign in_ready  = (state_reg == ST_RUN) && (!out_valid_reg || out_ready) && !rst;

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        len_next       = len_reg;
        cnt_next       = cnt_reg;
        carry_next     = carry_reg;
        zero_next      = zero_reg;
        ov_next        = ov_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        done_next      = 1'b0;
        done_co_next   = done_co_reg;
        done_ov_next   = done_ov_reg;
        done_zero_next = done_zero_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_next    = alu_op_e'(cmd_op);
                    len_next   = cmd_len;
                    carry_next = cmd_ci && is_arith(alu_op_e'(cmd_op));
                    zero_next  = 1'b1;
                    ov_next    = 1'b0;
                    cnt_next   = '0;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid && in_ready) begin
                    out_data_next  = limb_r;
                    out_valid_next = 1'b1;
                    out_last_next  = (cnt_reg == len_reg);
                    carry_next     = limb_co;
                    zero_next      = zero_reg && (limb_r == '0);
                    ov_next        = limb_ov;
                    cnt_next       = cnt_reg + 1'b1;
                    if (cnt_reg == len_reg) begin
                        state_next = ST_DRAIN;
                    end
                end else if (out_valid_reg && out_ready) begin
                    out_valid_next = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    out_last_next  = 1'b0;
                    done_next      = 1'b1;
                    done_co_next   = carry_reg;
                    done_ov_next   = ov_reg;
                    done_zero_next = zero_reg;
                    state_next     = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_NOP;
            len_reg       <= '0;
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            zero_reg      <= 1'b0;
            ov_reg        <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
            done_co_reg   <= 1'b0;
            done_ov_reg   <= 1'b0;
            done_zero_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            len_reg       <= len_next;
            cnt_reg       <= cnt_next;
            carry_reg     <= carry_next;
            zero_reg      <= zero_next;
            ov_reg        <= ov_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            done_reg      <= done_next;
            done_co_reg   <= done_co_next;
            done_ov_reg   <= done_ov_next;
            done_zero_reg <= done_zero_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign done      = done_reg;
    assign done_co   = done_co_reg;
    assign done_ov   = done_ov_reg;
    assign done_zero = done_zero_reg;

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_cmds_reg, stat_limbs_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cmds_reg  <= '0;
            stat_limbs_reg <= '0;
        end else begin
            if (done_next && stat_cmds_reg != 16'hFFFF) begin
                stat_cmds_reg <= stat_cmds_reg + 16'd1;
            end
            if (in_valid && in_ready && stat_limbs_reg != 16'hFFFF) begin
                stat_limbs_reg <= stat_limbs_reg + 16'd1;
            end
        end
    end

    assign stat_cmds  = stat_cmds_reg;
    assign stat_limbs = stat_limbs_reg;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq; expected results come from a
// full-width integer model of each command. Build with ALU_SEQ_STATS_EN to check counters.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_len;
    logic        cmd_ci;
    logic        in_valid, in_ready;
    logic [7:0]  in_a, in_b;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        done, done_co, done_ov, done_zero;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_cmds, stat_limbs;
`endif

    int total = 0;
    int bad   = 0;
    int exp_cmds  = 0;
    int exp_limbs = 0;

    alu_seq #(.WIDTH(8), .MAX_LIMBS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_ci    (cmd_ci),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .done_co   (done_co),
        .done_ov   (done_ov),
        .done_zero (done_zero)
`ifdef ALU_SEQ_STATS_EN
        , .stat_cmds  (stat_cmds)
        , .stat_limbs (stat_limbs)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one command to completion. mode 0: always ready, 1: random
    // valid/ready, 2: out_ready held low for three cycles mid-stream.
    task automatic run_cmd(input logic [2:0] op, input int len, input logic ci,
                           input logic [127:0] a, input logic [127:0] b, input int mode);
        int n, nbits, sent, recv;
        logic [128:0] mask, aa, bb, full;
        logic [127:0] res;
        logic exp_co, exp_ov, exp_z, sa, sb, sr;
        logic held, finished, accepted;
        logic [7:0] held_data, exp_limb;

        n     = len + 1;
        nbits = n * 8;
        mask  = (129'd1 << nbits) - 129'd1;
        aa    = {1'b0, a} & mask;
        bb    = {1'b0, b} & mask;
        full  = '0;
        exp_co = 1'b0;
        case (op)
            3'd2: begin full = aa + bb + {128'd0, ci}; exp_co = full[nbits]; end
            3'd3: begin full = aa - bb - {128'd0, ci}; exp_co = full[nbits]; end
            3'd4: full = ~aa;
            3'd5: full = aa & bb;
            3'd6: full = aa | bb;
            3'd7: full = aa ^ bb;
            default: full = bb;
        endcase
        res = full[127:0] & mask[127:0];
        sa = aa[nbits-1];
        sb = bb[nbits-1];
        sr = res[nbits-1];
        exp_ov = 1'b0;
        if (op == 3'd2) exp_ov = (sa == sb) && (sr != sa);
        if (op == 3'd3) exp_ov = (sa != sb) && (sr != sa);
        exp_z = (res == '0);

        accepted = 1'b0;
        for (int c = 0; c < 20 && !accepted; c++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_op    = op;
            cmd_len   = 4'(len);
            cmd_ci    = ci;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            #1;
            accepted = cmd_ready;
        end
        check_eq("cmd_accept", {31'd0, accepted}, 32'd1);

        sent = 0;
        recv = 0;
        held = 1'b0;
        held_data = '0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (done) begin
                check_eq("done_count", recv, n);
                check_eq("done_co", {31'd0, done_co}, {31'd0, exp_co});
                check_eq("done_ov", {31'd0, done_ov}, {31'd0, exp_ov});
                check_eq("done_zero", {31'd0, done_zero}, {31'd0, exp_z});
                check_eq("cmd_ready_at_done", {31'd0, cmd_ready}, 32'd1);
                exp_cmds++;
                finished = 1'b1;
                in_valid  = 1'b0;
                out_ready = 1'b0;
            end else begin
                in_valid = (sent < n) && (mode != 1 || ($urandom % 4) != 0);
                in_a = a[(sent % 16) * 8 +: 8];
                in_b = b[(sent % 16) * 8 +: 8];
                case (mode)
                    0: out_ready = 1'b1;
                    1: out_ready = ($urandom % 4) != 0;
                    default: out_ready = !(cyc >= 3 && cyc < 6);
                endcase
                #1;
                if (out_valid && !out_ready) begin
                    check_eq("in_ready_bp", {31'd0, in_ready}, 32'd0);
                end
                if (held) begin
                    check_eq("out_hold", {24'd0, out_data}, {24'd0, held_data});
                end
                held = out_valid && !out_ready;
                held_data = out_data;
                if (out_valid && out_ready) begin
                    exp_limb = res[(recv % 16) * 8 +: 8];
                    check_eq("out_data", {24'd0, out_data}, {24'd0, exp_limb});
                    check_eq("out_last", {31'd0, out_last}, {31'd0, recv == n - 1});
                    recv++;
                end
                if (in_valid && in_ready) begin
                    sent++;
                    exp_limbs++;
                end
            end
        end
        if (!finished) check_eq("timeout", 32'd0, 32'd1);
        $display("cmd op=%0d len=%0d ci=%0d mode=%0d res=%0h co=%0d ov=%0d z=%0d",
                 op, len, ci, mode, res, exp_co, exp_ov, exp_z);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_ci = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        check_eq("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("idle_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_eq("idle_no_out", {31'd0, out_valid}, 32'd0);

        run_cmd(3'd2, 1, 1'b0, 128'h00FF, 128'h0001, 0);
        run_cmd(3'd3, 1, 1'b0, 128'h0000, 128'h0001, 0);
        run_cmd(3'd2, 1, 1'b0, 128'h7FFF, 128'h0001, 0);
        run_cmd(3'd7, 0, 1'b1, 128'h00A5, 128'h00A5, 0);
        run_cmd(3'd2, 3, 1'b1, 128'h89AB_CDEF, 128'h7654_3210, 2);
        for (int i = 0; i < 40; i++) begin
            run_cmd(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1'($urandom % 2),
                    {$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom}, 1);
        end
`ifdef ALU_SEQ_STATS_EN
        check_eq("stat_cmds", {16'd0, stat_cmds}, exp_cmds);
        check_eq("stat_limbs", {16'd0, stat_limbs}, exp_limbs);
`endif

        // Abort an ADD after two limbs, then verify a clean restart.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_len = 4'd3; cmd_ci = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_a = 8'h11; in_b = 8'h22;
        @(negedge clk);
        in_a = 8'h33; in_b = 8'h44;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("abort_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_eq("abort_no_done", {31'd0, done}, 32'd0);
        end
        exp_cmds = 0;
        exp_limbs = 0;
        run_cmd(3'd2, 3, 1'b0, 128'hFFFF_FFFF, 128'h0000_0001, 0);
`ifdef ALU_SEQ_STATS_EN
        check_eq("stat_cmds_after_rst", {16'd0, stat_cmds}, exp_cmds);
        check_eq("stat_limbs_after_rst", {16'd0, stat_limbs}, exp_limbs);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-precision sequencer that drives one `alu` instance (WIDTH bits) limb by limb, least-significant limb first.
- Chains carry/borrow between limbs, so ADD/SUB run at N×WIDTH bits.
- Accepts one command, consumes the operand limb stream, produces the result limb stream and a final status pulse.
- Sits between the operand/instruction front-end and the result writeback.

Parameters:
- WIDTH, 8, limb width passed to the `alu` instance.
- MAX_LIMBS, 16, maximum limbs per command.
- LEN_W, $clog2(MAX_LIMBS), width of the limb-count field (derived, not overridden).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready
- cmd_op  input  3  ALU opcode: 000 NOP, 001 LD, 010 ADD, 011 SUB, 100 NOT, 101 AND, 110 OR, 111 XOR
- cmd_len  input  LEN_W  limb count minus 1 (0 = one limb)
- cmd_ci  input  1  carry/borrow into limb 0 (ADD/SUB only)
- in_valid  input  1  operand limb pair offered
- in_ready  output  1  operand pair accepted when in_valid&&in_ready
- in_a  input  WIDTH  operand A limb
- in_b  input  WIDTH  operand B limb
- out_valid  output  1  result limb valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  result limb
- out_last  output  1  marks the final limb of the command
- done  output  1  one-cycle pulse after the last limb transfers out
- done_co  output  1  final carry (ADD) / borrow (SUB); 0 for other ops
- done_ov  output  1  signed overflow of the full-width ADD/SUB; 0 for other ops
- done_zero  output  1  all result limbs were zero

Behaviour:
- Reset: clocked, synchronous, active-high; all outputs 0, state IDLE, carry/count/zero registers cleared. The rule for rst asserted mid-command is under Boundaries.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - cmd_ready=1, in_ready=0.
  - On command handshake: latch op, len, and carry_reg=cmd_ci (forced 0 unless op is ADD/SUB); set zero_acc=1, cnt=0; go to RUN.
- RUN:
  - in_ready = !out_valid || out_ready (one-deep output register, no bubble under full throughput).
  - On input handshake, next cycle: out_data=ALU result of (op, in_a, in_b, carry_reg); out_valid=1; out_last=(cnt==len).
  - On input handshake, registers update: carry_reg=limb carry/borrow out; zero_acc&=(result==0); cnt++.
  - Input latency: 1 cycle.
  - After the handshake on limb cnt==len, go to DRAIN with in_ready=0.
- Carry/borrow rule: ADD limb = a+b+carry_reg and SUB limb = a-b-carry_reg, each computed at WIDTH+1 bits; bit WIDTH is the next carry (ADD) or borrow (SUB).
- Overflow rule: ov is computed on the top limb only.
  - ADD: ov = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - SUB: ov = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - NOP/LD pass in_b; logic ops never chain carry.
- DRAIN:
  - Hold out_data and out_valid until out_ready.
  - On the last-limb handshake: out_valid=0; done=1 for one cycle with done_co=carry_reg, done_ov, done_zero=zero_acc; go to IDLE.
  - done_* hold their value until the next done.
  - cmd_ready returns to 1 in the cycle done is high.
- Boundaries:
  - cmd_len=0: single limb; out_last=1 on the first result.
  - out_ready low: out_data/out_last held stable and in_ready=0; no limb is dropped or duplicated.
  - in_valid while IDLE is ignored (in_ready=0).
  - A new cmd is not accepted before done.
  - rst asserted mid-command: returns to IDLE next edge; partial results are discarded and no done pulse is generated.

Optional Feature:
- Macro ALU_SEQ_STATS_EN.
- Defined:
  - Extra outputs stat_cmds (16 bits, ++ on each done) and stat_limbs (16 bits, ++ on each input handshake).
  - Both saturate at 0xFFFF and clear on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_seq_pkg:
  - alu_op_e enum (the 8 opcodes above).
  - seq_state_e enum (IDLE, RUN, DRAIN).
  - is_arith(op) function.
- Sub-module: one `alu` instance for the limb result.
- Carry/borrow/ov follow the rules above; they are derived in alu_seq from the WIDTH+1-bit limb arithmetic, so correctness is independent of the `alu` flag outputs.

Test Plan:
- WIDTH=8, ADD, len=1, ci=0, limbs (FF,01),(00,00) -> out 00 then 01 (last), done_co=0, done_ov=0, done_zero=0.
- SUB, len=1, ci=0, limbs (00,01),(00,00) -> out FF, FF, done_co=1, done_ov=0.
- ADD, len=1, limbs (FF,01),(7F,00) [0x7FFF+1] -> out 00, 80, done_ov=1, done_co=0.
- XOR, len=0, ci=1, (A5,A5) -> out 00, out_last=1, done_co=0, done_zero=1.
- Backpressure: ADD len=3 with out_ready low 3 cycles mid-stream -> in_ready=0, out_data stable, all 4 limbs correct and in order.
- rst asserted during RUN after limb 1 -> next cycle IDLE, out_valid=0, no done; a fresh command then completes correctly. With ALU_SEQ_STATS_EN, stat_cmds counts completed commands only.
